alu_sequencer: RTL and testbench

//  Multi-cycle controller between the control unit and the 32-bit ALU (5-bit op_code, 64-bit out).

---
 rtl/alu_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle controller that sits between the control unit and the 32-bit ALU.
// It latches the operands, waits a latency that depends on the opcode, then captures the 64-bit result.
module alu_sequencer #(
  parameter int unsigned LAT_SIMPLE = 1,
  parameter int unsigned LAT_MUL    = 4,
  parameter int unsigned LAT_DIV    = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [4:0]  op_code,
  input  logic [31:0] in_A,
  input  logic [31:0] in_B,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [4:0]  alu_op,
  input  logic [63:0] alu_out,
  output logic        busy,
  output logic        done,
  output logic [31:0] z_lo,
  output logic [31:0] z_hi,
  output logic        illegal_op,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] OP_MUL = 5'd12;
  localparam logic [4:0] OP_DIV = 5'd13;

  // Counter preload is latency-1: the capture happens on the edge where cnt is already zero.
  localparam logic [7:0] CNT_SIMPLE = 8'(LAT_SIMPLE - 1);
  localparam logic [7:0] CNT_MUL    = 8'(LAT_MUL - 1);
  localparam logic [7:0] CNT_DIV    = 8'(LAT_DIV - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] cnt_load;
  logic       op_bad;
  logic       op_divz;

  always_comb begin
    cnt_load = CNT_SIMPLE;
    if (op_code == OP_MUL) cnt_load = CNT_MUL;
    else if (op_code == OP_DIV) cnt_load = CNT_DIV;
  end

  assign op_bad  = (op_code == 5'd0) || (op_code > OP_DIV);
  assign op_divz = (op_code == OP_DIV) && (in_B == 32'd0);

  // Single state machine; busy and done are registered alongside the state they decode.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      alu_A      <= 32'd0;
      alu_B      <= 32'd0;
      alu_op     <= 5'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      z_lo       <= 32'd0;
      z_hi       <= 32'd0;
      illegal_op <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy   <= 1'b0;
          done   <= 1'b0;
          alu_op <= 5'd0;
          if (start) begin
            // Rejected requests skip EXEC entirely and leave operands and Z untouched.
            if (op_bad) begin
              illegal_op <= 1'b1;
              div_zero   <= 1'b0;
              busy       <= 1'b1;
              done       <= 1'b1;
              state      <= DONE;
            end else if (op_divz) begin
              illegal_op <= 1'b0;
              div_zero   <= 1'b1;
              busy       <= 1'b1;
              done       <= 1'b1;
              state      <= DONE;
            end else begin
              alu_A      <= in_A;
              alu_B      <= in_B;
              alu_op     <= op_code;
              illegal_op <= 1'b0;
              div_zero   <= 1'b0;
              cnt        <= cnt_load;
              busy       <= 1'b1;
              state      <= EXEC;
            end
          end
        end
        EXEC: begin
          busy <= 1'b1;
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            z_hi   <= alu_out[63:32];
            z_lo   <= alu_out[31:0];
            alu_op <= 5'd0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy   <= 1'b0;
          done   <= 1'b0;
          alu_op <= 5'd0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer; a small behavioural ALU closes the loop on alu_out.
module tb_alu_sequencer;

  logic        clk;
  logic        clr;
  logic        start;
  logic [4:0]  op_code;
  logic [31:0] in_A;
  logic [31:0] in_B;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [4:0]  alu_op;
  logic [63:0] alu_out;
  logic        busy;
  logic        done;
  logic [31:0] z_lo;
  logic [31:0] z_hi;
  logic        illegal_op;
  logic        div_zero;

  int assertCount = 0;
  int failCount   = 0;
  int edges;
  int busyCycles;

  alu_sequencer #(.LAT_SIMPLE(1), .LAT_MUL(4), .LAT_DIV(8)) dut (
    .clk(clk), .clr(clr), .start(start), .op_code(op_code),
    .in_A(in_A), .in_B(in_B), .alu_A(alu_A), .alu_B(alu_B),
    .alu_op(alu_op), .alu_out(alu_out), .busy(busy), .done(done),
    .z_lo(z_lo), .z_hi(z_hi), .illegal_op(illegal_op), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: upper word holds the MUL high half or the DIV remainder.
  always_comb begin
    alu_out = 64'd0;
    case (alu_op)
      5'd1:  alu_out = {32'd0, alu_A | alu_B};
      5'd10: alu_out = {32'd0, alu_A + alu_B};
      5'd11: alu_out = {32'd0, alu_A - alu_B};
      5'd12: alu_out = {32'd0, alu_A} * {32'd0, alu_B};
      5'd13: alu_out = (alu_B == 32'd0) ? 64'd0 : {alu_A % alu_B, alu_A / alu_B};
      default: alu_out = 64'd0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one start request in IDLE; returns #1 after the sampling edge T.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    op_code = op;
    in_A    = a;
    in_B    = b;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after T until done is seen, and how many sampled cycles had busy high.
  task automatic waitDone(output int nEdges, output int nBusy);
    nEdges = 0;
    nBusy  = 0;
    while (!done && nEdges < 40) begin
      if (busy) nBusy++;
      @(posedge clk);
      #1;
      nEdges++;
    end
    if (done) nBusy += busy ? 1 : 0;
    else checkOutput("done_timeout", 64'(nEdges), 64'd0);
  endtask

  initial begin
    clr     = 1'b1;
    start   = 1'b0;
    op_code = 5'd0;
    in_A    = 32'd0;
    in_B    = 32'd0;
    #12;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_aluop", 64'(alu_op), 64'd0);
    checkOutput("rst_z", {z_hi, z_lo}, 64'd0);
    checkOutput("rst_flags", {62'd0, illegal_op, div_zero}, 64'd0);
    @(negedge clk);
    clr = 1'b0;

    $display("[TB] test 1: ADD 5+7");
    applyStimulus(5'd10, 32'd5, 32'd7);
    checkOutput("add_aluop", 64'(alu_op), 64'd10);
    checkOutput("add_aluA", 64'(alu_A), 64'd5);
    checkOutput("add_busy", 64'(busy), 64'd1);
    in_A = 32'd100;
    waitDone(edges, busyCycles);
    checkOutput("add_lat", 64'(edges), 64'd1);
    checkOutput("add_z", {z_hi, z_lo}, 64'd12);
    checkOutput("add_aluop_done", 64'(alu_op), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("add_done_pulse", {62'd0, done, busy}, 64'd0);

    $display("[TB] test 2: MUL 0x10000*0x10000");
    applyStimulus(5'd12, 32'h0001_0000, 32'h0001_0000);
    waitDone(edges, busyCycles);
    checkOutput("mul_lat", 64'(edges), 64'd4);
    checkOutput("mul_busy_cycles", 64'(busyCycles), 64'd5);
    checkOutput("mul_z", {z_hi, z_lo}, 64'h0000_0001_0000_0000);

    $display("[TB] test 3: DIVIDE by zero");
    applyStimulus(5'd10, 32'h1234, 32'd0);
    waitDone(edges, busyCycles);
    checkOutput("preload_z", {z_hi, z_lo}, 64'h1234);
    applyStimulus(5'd13, 32'd7, 32'd0);
    checkOutput("divz_aluop", 64'(alu_op), 64'd0);
    waitDone(edges, busyCycles);
    checkOutput("divz_lat", 64'(edges), 64'd0);
    checkOutput("divz_flags", {62'd0, illegal_op, div_zero}, 64'd1);
    checkOutput("divz_z", {z_hi, z_lo}, 64'h1234);
    checkOutput("divz_aluA", 64'(alu_A), 64'h1234);

    $display("[TB] test 4: illegal opcode then SUB");
    applyStimulus(5'b11111, 32'd1, 32'd1);
    waitDone(edges, busyCycles);
    checkOutput("ill_lat", 64'(edges), 64'd0);
    checkOutput("ill_flags", {62'd0, illegal_op, div_zero}, 64'd2);
    checkOutput("ill_z", {z_hi, z_lo}, 64'h1234);
    applyStimulus(5'd11, 32'd9, 32'd4);
    waitDone(edges, busyCycles);
    checkOutput("sub_lat", 64'(edges), 64'd1);
    checkOutput("sub_flags", {62'd0, illegal_op, div_zero}, 64'd0);
    checkOutput("sub_z", {z_hi, z_lo}, 64'd5);

    $display("[TB] test 5: DIVIDE 100/7 with start pulsed while busy");
    applyStimulus(5'd13, 32'd100, 32'd7);
    @(posedge clk);
    #1;
    op_code = 5'd10;
    in_A    = 32'd1;
    in_B    = 32'd1;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("div_aluop_held", 64'(alu_op), 64'd13);
    checkOutput("div_aluB_held", 64'(alu_B), 64'd7);
    waitDone(edges, busyCycles);
    checkOutput("div_lat", 64'(edges + 2), 64'd8);
    checkOutput("div_z", {z_hi, z_lo}, {32'd2, 32'd14});
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("div_no_queue", {62'd0, busy, done}, 64'd0);
    end

    $display("[TB] test 6: reset during DIVIDE");
    applyStimulus(5'd13, 32'd50, 32'd5);
    repeat (3) @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    checkOutput("clr_busy", 64'(busy), 64'd0);
    checkOutput("clr_aluop", 64'(alu_op), 64'd0);
    checkOutput("clr_z", {z_hi, z_lo}, 64'd0);
    @(negedge clk);
    clr = 1'b0;
    applyStimulus(5'd10, 32'd3, 32'd4);
    waitDone(edges, busyCycles);
    checkOutput("post_clr_lat", 64'(edges), 64'd1);
    checkOutput("post_clr_z", {z_hi, z_lo}, 64'd7);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
